// File: rtl/nbit_reg_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nbit_reg_arbiter_pkg
//  Purpose  : Shared state encoding and helper function for the write-port
//             arbiter of a shared WIDTH-bit register.
//  Revision : 1.0  initial release
// ============================================================================
package nbit_reg_arbiter_pkg;

    // Arbiter FSM states, 2-bit encoded
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_t;

    // Ceiling log2, never less than 1 so it can size a vector directly
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage : nbit_reg_arbiter_pkg
`default_nettype wire

// File: rtl/nbit_reg_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : nbit_reg_arbiter_rr_pick
//  Purpose  : Combinational round-robin picker. Search starts one position
//             after ptr and wraps, so the requester at ptr has lowest priority.
//  Revision : 1.0  initial release
// ============================================================================
module nbit_reg_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] win,
    output logic [IDW-1:0]  win_id,
    output logic            any
);

    int   idx;
    logic found;

    assign any = |req;

    // First asserted request after ptr, wrapping modulo NREQ
    always_comb begin
        win    = '0;
        win_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                win[idx] = 1'b1;
                win_id   = IDW'(idx);
            end
        end
    end

endmodule : nbit_reg_arbiter_rr_pick
`default_nettype wire

// File: rtl/nbit_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : nbit_reg_arbiter
//  Purpose  : Round-robin write-port arbiter for one shared WIDTH-bit register.
//             Registered one-hot grant, optional burst lock bounded by
//             MAX_HOLD, and a data mux feeding the register's d/en inputs.
//  Revision : 1.0  initial release
// ============================================================================
module nbit_reg_arbiter
    import nbit_reg_arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [IDW-1:0]        owner,
    output logic                  busy,
    output logic [WIDTH-1:0]      reg_d,
    output logic                  reg_en
);

    // hold_cnt only ever reaches MAX_HOLD-1
    localparam int HCW = clog2(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] PTR_RESET = IDW'(NREQ - 1);

    arb_state_t       state;
    logic [HCW-1:0]   hold_cnt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   pick_ptr;
    logic [NREQ-1:0]  win;
    logic [IDW-1:0]   win_id;
    logic             any;
    logic             lock_win;
    logic             keep_lock;
    logic [WIDTH-1:0] slice [NREQ];

    // Split the flat write-data bus into one word per requester
    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_slice
            assign slice[i] = wdata[i*WIDTH +: WIDTH];
        end
    endgenerate

    // From IDLE the saved pointer decides; while granted, the current owner
    // is the pointer so it drops to lowest priority on re-arbitration.
    assign pick_ptr = (state == ST_IDLE) ? rr_ptr : owner;

    nbit_reg_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .win    (win),
        .win_id (win_id),
        .any    (any)
    );

    assign lock_win  = |(win & lock);
    assign keep_lock = (state == ST_LOCKED) && req[owner] && lock[owner]
                       && (hold_cnt != HOLD_LAST);

    // A write happens only while the grantee still requests
    assign reg_en = |(gnt & req);
    assign reg_d  = reg_en ? slice[owner] : '0;

    // Arbiter FSM: grant, lock hold and round-robin pointer update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            rr_ptr   <= PTR_RESET;
        end else begin
            case (state)
                ST_LOCKED: begin
                    if (keep_lock) begin
                        hold_cnt <= hold_cnt + HCW'(1);
                    end else begin
                        rr_ptr   <= owner;
                        hold_cnt <= '0;
                        if (any) begin
                            gnt   <= win;
                            owner <= win_id;
                            busy  <= 1'b1;
                            state <= lock_win ? ST_LOCKED : ST_GRANT;
                        end else begin
                            gnt   <= '0;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_GRANT: begin
                    rr_ptr   <= owner;
                    hold_cnt <= '0;
                    if (any) begin
                        gnt   <= win;
                        owner <= win_id;
                        busy  <= 1'b1;
                        state <= lock_win ? ST_LOCKED : ST_GRANT;
                    end else begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    hold_cnt <= '0;
                    if (any) begin
                        gnt   <= win;
                        owner <= win_id;
                        busy  <= 1'b1;
                        state <= lock_win ? ST_LOCKED : ST_GRANT;
                    end else begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule : nbit_reg_arbiter
`default_nettype wire

// File: tb/tb_nbit_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nbit_reg_arbiter
//  Purpose  : Self-checking bench for nbit_reg_arbiter with a grant-level
//             reference model and a behavioural shared register.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nbit_reg_arbiter;

    localparam int WIDTH    = 32;
    localparam int NREQ     = 4;
    localparam int IDW      = 2;
    localparam int MAX_HOLD = 4;

    logic                  clk;
    logic                  reset_n;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [IDW-1:0]        owner;
    logic                  busy;
    logic [WIDTH-1:0]      reg_d;
    logic                  reg_en;
    logic [WIDTH-1:0]      q = '0;

    int compared   = 0;
    int mismatched = 0;

    // reference model: current grantee (-1 = none), last owner, hold length
    int          m_cur;
    int          m_owner;
    int          m_cnt;
    int          m_ptr;
    bit          m_locked;
    logic [31:0] m_q = '0;

    logic [3:0] lock_seq [7] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h1};

    nbit_reg_arbiter #(
        .WIDTH    (WIDTH),
        .NREQ     (NREQ),
        .IDW      (IDW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .lock    (lock),
        .wdata   (wdata),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .reg_d   (reg_d),
        .reg_en  (reg_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // the shared register the arbiter drives
    always @(posedge clk) begin
        if (reg_en) q <= reg_d;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m_cur    = -1;
        m_owner  = 0;
        m_cnt    = 0;
        m_ptr    = NREQ - 1;
        m_locked = 1'b0;
    endtask

    function automatic logic exp_en();
        return (m_cur >= 0) && req[m_cur];
    endfunction

    function automatic logic [31:0] exp_d();
        return exp_en() ? wdata[m_cur*WIDTH +: WIDTH] : 32'h0;
    endfunction

    task automatic check_model();
        chk("gnt",   32'(gnt),    (m_cur >= 0) ? (32'h1 << m_cur) : 32'h0);
        chk("busy",  32'(busy),   32'(m_cur >= 0));
        chk("owner", 32'(owner),  32'(m_owner));
        chk("reg_en",32'(reg_en), 32'(exp_en()));
        chk("reg_d", reg_d,       exp_d());
        chk("q",     q,           m_q);
    endtask

    // advance the model by one clock edge using the inputs present now
    task automatic model_next();
        int base;
        int nxt;
        if (exp_en()) m_q = exp_d();
        if (m_cur >= 0 && m_locked && req[m_cur] && lock[m_cur] && m_cnt < MAX_HOLD - 1) begin
            m_cnt++;
        end else begin
            base = (m_cur >= 0) ? m_cur : m_ptr;
            if (m_cur >= 0) m_ptr = m_cur;
            nxt = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (nxt < 0 && req[(base + k) % NREQ]) nxt = (base + k) % NREQ;
            end
            m_cur = nxt;
            m_cnt = 0;
            if (nxt >= 0) begin
                m_owner  = nxt;
                m_locked = lock[nxt];
            end
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input bit new_data);
        req  = r;
        lock = l;
        if (new_data) wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        #1;
        check_model();
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rq;
        logic [3:0] lk;

        // reset held with all requests pending
        reset_n = 1'b0;
        req     = 4'hF;
        lock    = 4'h0;
        wdata   = '0;
        mreset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",   32'(gnt),    32'h0);
        chk("rst_busy",  32'(busy),   32'h0);
        chk("rst_en",    32'(reg_en), 32'h0);
        chk("rst_owner", 32'(owner),  32'h0);
        reset_n = 1'b1;

        // rotation with every requester active, starting at requester 0
        drive(4'hF, 4'h0, 1'b1);
        chk("rot_idle", 32'(gnt), 32'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(4'hF, 4'h0, 1'b1);
            chk("rot_gnt", 32'(gnt), 32'h1 << (i % 4));
            chk("rot_en",  32'(reg_en), 32'h1);
            tick();
        end
        drive(4'h0, 4'h0, 1'b1);
        tick();
        drive(4'h0, 4'h0, 1'b1);
        chk("idle_busy", 32'(busy), 32'h0);
        tick();

        // single requester 2 writes a known word
        wdata = '0;
        wdata[95:64] = 32'hA5A5_0001;
        drive(4'b0100, 4'h0, 1'b0);
        tick();
        drive(4'b0100, 4'h0, 1'b0);
        chk("single_gnt", 32'(gnt),    32'h4);
        chk("single_en",  32'(reg_en), 32'h1);
        chk("single_d",   reg_d,       32'hA5A5_0001);
        tick();
        drive(4'b0000, 4'h0, 1'b0);
        chk("single_q", q, 32'hA5A5_0001);
        tick();

        // lock timeout: requester 0 holds exactly MAX_HOLD cycles
        for (int i = 0; i < 7; i++) begin
            drive(4'b0011, 4'b0001, 1'b1);
            chk("lock_gnt", 32'(gnt), 32'(lock_seq[i]));
            tick();
        end
        drive(4'h0, 4'h0, 1'b1);
        tick();

        // locked grantee drops its request in the second grant cycle
        drive(4'b0110, 4'b0010, 1'b1);
        tick();
        drive(4'b0110, 4'b0010, 1'b1);
        chk("drop_gnt1", 32'(gnt), 32'h2);
        chk("drop_en1",  32'(reg_en), 32'h1);
        tick();
        drive(4'b0100, 4'b0010, 1'b1);
        chk("drop_gnt2", 32'(gnt), 32'h2);
        chk("drop_en2",  32'(reg_en), 32'h0);
        tick();
        drive(4'b0100, 4'b0000, 1'b1);
        chk("drop_next", 32'(gnt), 32'h4);
        tick();
        drive(4'h0, 4'h0, 1'b1);
        tick();

        // reset in the third locked cycle
        drive(4'b1000, 4'b1000, 1'b1);
        tick();
        drive(4'b1000, 4'b1000, 1'b1);
        tick();
        drive(4'b1000, 4'b1000, 1'b1);
        tick();
        drive(4'b1000, 4'b1000, 1'b1);
        chk("ml_gnt", 32'(gnt), 32'h8);
        #1;
        reset_n = 1'b0;
        mreset();
        #1;
        chk("ml_rst_gnt", 32'(gnt),    32'h0);
        chk("ml_rst_en",  32'(reg_en), 32'h0);
        check_model();
        @(posedge clk);
        #1;
        chk("ml_q_kept", q, m_q);
        reset_n = 1'b1;

        // randomized traffic with sticky requests and locks
        rq = 4'h0;
        lk = 4'h0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom());
            if ($urandom_range(0, 3) == 0) lk = 4'($urandom() & $urandom());
            drive(rq, lk, 1'b1);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_nbit_reg_arbiter
`default_nettype wire
